// File: rtl/bcd_time_counter.sv
// bcd_time_counter: 1 Hz prescaler plus packed-BCD HH:MM:SS time keeping.
// Build option: define CLOCK_12H_EN for a 12-hour display (12, 01..11) with a
// PM indicator; leave it undefined for a 24-hour display (00..23), pm tied to 0.
// Every digit is held in its own 4-bit BCD register, so outputs are always 0-9.

module bcd_time_counter #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       set_min,
    input  logic       set_hr,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic [3:0] hr_u,
    output logic [3:0] hr_t,
    output logic       tick_1hz,
    output logic       pm
);

    localparam int unsigned PW = $clog2(CLK_HZ);
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

`ifdef CLOCK_12H_EN
    localparam logic [3:0] RST_HR_T = 4'd1;
    localparam logic [3:0] RST_HR_U = 4'd2;
`else
    localparam logic [3:0] RST_HR_T = 4'd0;
    localparam logic [3:0] RST_HR_U = 4'd0;
`endif

    // State registers
    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic [3:0]    sec_u_q, sec_u_d, sec_t_q, sec_t_d;
    logic [3:0]    min_u_q, min_u_d, min_t_q, min_t_d;
    logic [3:0]    hr_u_q, hr_u_d, hr_t_q, hr_t_d;

    // Incremented views of each field and their wrap flags
    logic          tick;
    logic [3:0]    sec_u_inc, sec_t_inc, min_u_inc, min_t_inc, hr_u_inc, hr_t_inc;
    logic          sec_wrap, min_wrap;

`ifdef CLOCK_12H_EN
    logic          pm_q, pm_d;
    logic          pm_flip;
`endif

    // Prescaler wrap: only while running, on the last count of the second
    assign tick = run && (presc_q == PRESC_MAX);

    // Seconds and minutes +1 in BCD; ">=" keeps any out-of-range digit self-correcting
    always_comb begin
        sec_u_inc = sec_u_q + 4'd1;
        sec_t_inc = sec_t_q;
        sec_wrap  = 1'b0;
        if (sec_u_q >= 4'd9) begin
            sec_u_inc = 4'd0;
            if (sec_t_q >= 4'd5) begin
                sec_t_inc = 4'd0;
                sec_wrap  = 1'b1;
            end else begin
                sec_t_inc = sec_t_q + 4'd1;
            end
        end

        min_u_inc = min_u_q + 4'd1;
        min_t_inc = min_t_q;
        min_wrap  = 1'b0;
        if (min_u_q >= 4'd9) begin
            min_u_inc = 4'd0;
            if (min_t_q >= 4'd5) begin
                min_t_inc = 4'd0;
                min_wrap  = 1'b1;
            end else begin
                min_t_inc = min_t_q + 4'd1;
            end
        end
    end

    // Hours +1 following the configured display sequence
    always_comb begin
        hr_u_inc = hr_u_q + 4'd1;
        hr_t_inc = hr_t_q;
`ifdef CLOCK_12H_EN
        pm_flip  = 1'b0;
        if (hr_t_q >= 4'd1 && hr_u_q >= 4'd2) begin
            // 12 -> 01, same half of the day
            hr_t_inc = 4'd0;
            hr_u_inc = 4'd1;
        end else if (hr_t_q >= 4'd1 && hr_u_q == 4'd1) begin
            // 11 -> 12 crosses noon/midnight
            hr_t_inc = 4'd1;
            hr_u_inc = 4'd2;
            pm_flip  = 1'b1;
        end else if (hr_u_q >= 4'd9) begin
            hr_t_inc = 4'd1;
            hr_u_inc = 4'd0;
        end
`else
        if (hr_t_q >= 4'd2 && hr_u_q >= 4'd3) begin
            hr_t_inc = 4'd0;
            hr_u_inc = 4'd0;
        end else if (hr_u_q >= 4'd9) begin
            hr_t_inc = hr_t_q + 4'd1;
            hr_u_inc = 4'd0;
        end
`endif
    end

    // Next state: set pulses take precedence over a tick, which is then dropped
    always_comb begin
        presc_d = presc_q;
        tick_d  = tick;
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        hr_u_d  = hr_u_q;
        hr_t_d  = hr_t_q;
`ifdef CLOCK_12H_EN
        pm_d    = pm_q;
`endif

        if (run) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (set_min || set_hr) begin
            presc_d = '0;
            sec_u_d = 4'd0;
            sec_t_d = 4'd0;
            if (set_min) begin
                // Minutes wrap 59 -> 00 without touching hours
                min_u_d = min_u_inc;
                min_t_d = min_t_inc;
            end
            if (set_hr) begin
                hr_u_d = hr_u_inc;
                hr_t_d = hr_t_inc;
`ifdef CLOCK_12H_EN
                pm_d   = pm_q ^ pm_flip;
`endif
            end
        end else if (tick) begin
            sec_u_d = sec_u_inc;
            sec_t_d = sec_t_inc;
            if (sec_wrap) begin
                min_u_d = min_u_inc;
                min_t_d = min_t_inc;
                if (min_wrap) begin
                    hr_u_d = hr_u_inc;
                    hr_t_d = hr_t_inc;
`ifdef CLOCK_12H_EN
                    pm_d   = pm_q ^ pm_flip;
`endif
                end
            end
        end
    end

    // State update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            tick_q  <= 1'b0;
            sec_u_q <= 4'd0;
            sec_t_q <= 4'd0;
            min_u_q <= 4'd0;
            min_t_q <= 4'd0;
            hr_u_q  <= RST_HR_U;
            hr_t_q  <= RST_HR_T;
`ifdef CLOCK_12H_EN
            pm_q    <= 1'b0;
`endif
        end else begin
            presc_q <= presc_d;
            tick_q  <= tick_d;
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
            hr_u_q  <= hr_u_d;
            hr_t_q  <= hr_t_d;
`ifdef CLOCK_12H_EN
            pm_q    <= pm_d;
`endif
        end
    end

    assign sec_u    = sec_u_q;
    assign sec_t    = sec_t_q;
    assign min_u    = min_u_q;
    assign min_t    = min_t_q;
    assign hr_u     = hr_u_q;
    assign hr_t     = hr_t_q;
    assign tick_1hz = tick_q;
`ifdef CLOCK_12H_EN
    assign pm       = pm_q;
`else
    assign pm       = 1'b0;
`endif

endmodule
